// File: rtl/debug_probe_pkg.sv
// Shared types and constants for the debug probe multiplexer and its helpers.
package debug_probe_pkg;

    typedef enum logic [1:0] {
        LED_DIRECT    = 2'd0,
        LED_STRETCH   = 2'd1,
        LED_TOGGLE    = 2'd2,
        LED_HEARTBEAT = 2'd3
    } led_mode_e;

    localparam int SEL_W           = 8;
    localparam int SEL_SPAN        = 256;
    localparam int DEF_STRETCH_CYC = 2000000;
    localparam int DEF_HB_HALF     = 10000000;

endpackage

// File: rtl/probe_pulse_stretcher.sv
// Retriggerable pulse stretcher: a trigger holds out high for HOLD_CYC clocks,
// and a new trigger during the hold restarts the full interval.
module probe_pulse_stretcher
    import debug_probe_pkg::*;
#(
    parameter int HOLD_CYC = DEF_STRETCH_CYC
) (
    input  logic clk_20mhz,
    input  logic rst_n_20mhz,
    input  logic trig,
    input  logic flush,
    output logic out
);

    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic [CW-1:0] cnt_r;

    // Hold counter: loaded with HOLD_CYC-1 so out stays high exactly HOLD_CYC clocks.
    always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
        if (!rst_n_20mhz) begin
            cnt_r <= {CW{1'b0}};
            out   <= 1'b0;
        end else if (flush) begin
            cnt_r <= {CW{1'b0}};
            out   <= 1'b0;
        end else if (trig) begin
            cnt_r <= CW'(HOLD_CYC - 1);
            out   <= 1'b1;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            out   <= 1'b1;
        end else begin
            cnt_r <= {CW{1'b0}};
            out   <= 1'b0;
        end
    end

endmodule

// File: rtl/debug_probe_mux.sv
// Routes synchronized probe sources to debug pins and one status LED with
// direct, stretched, toggled and heartbeat-gated display modes plus an edge counter.
module debug_probe_mux
    import debug_probe_pkg::*;
#(
    parameter int NUM_SRC     = 64,
    parameter int NUM_DBG     = 4,
    parameter int STRETCH_CYC = DEF_STRETCH_CYC,
    parameter int HB_HALF     = DEF_HB_HALF,
    parameter int CNT_W       = 16
) (
    input  logic                       clk_20mhz,
    input  logic                       rst_n_20mhz,
    input  logic [NUM_SRC-1:0]         probe_in,
    input  logic [SEL_W-1:0]           led_sel,
    input  logic [1:0]                 led_mode,
    input  logic [SEL_W*NUM_DBG-1:0]   dbg_sel,
    input  logic                       cnt_clr,
    output logic                       STATE_LED1,
    output logic [NUM_DBG-1:0]         DEBUG_SIG,
    output logic [CNT_W-1:0]           edge_cnt
);

    localparam int HB_W = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

    // Out-of-range indices land in the zero padding above NUM_SRC.
    function automatic logic sel_bit(input logic [NUM_SRC-1:0] vec,
                                     input logic [SEL_W-1:0]   idx);
        logic [SEL_SPAN-1:0] ext;
        ext = SEL_SPAN'(vec);
        return ext[idx];
    endfunction

    logic [NUM_SRC-1:0] sync1_r;
    logic [NUM_SRC-1:0] sync2_r;
    logic [SEL_W-1:0]   sel_hist_r;
    led_mode_e          mode_hist_r;
    led_mode_e          mode_s;
    logic               src_s;
    logic               src_d_r;
    logic               primed_r;
    logic               cfg_chg_s;
    logic               edge_s;
    logic               toggle_r;
    logic               toggle_next_s;
    logic               stretch_out_s;
    logic               led_next_s;
    logic [NUM_DBG-1:0] dbg_next_s;
    logic [HB_W-1:0]    hb_cnt_r;
    logic               hb_phase_r;

    // Two-flop synchronizer for every asynchronous probe source.
    always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
        if (!rst_n_20mhz) begin
            sync1_r <= {NUM_SRC{1'b0}};
            sync2_r <= {NUM_SRC{1'b0}};
        end else begin
            sync1_r <= probe_in;
            sync2_r <= sync1_r;
        end
    end

    // LED source selection, config-change detection and edge qualification.
    always_comb begin
        mode_s    = led_mode_e'(led_mode);
        src_s     = sel_bit(sync2_r, led_sel);
        cfg_chg_s = (led_sel != sel_hist_r) || (mode_s != mode_hist_r);
        edge_s    = src_s & ~src_d_r & primed_r & ~cfg_chg_s;
        if (cfg_chg_s) begin
            toggle_next_s = 1'b0;
        end else begin
            toggle_next_s = toggle_r ^ edge_s;
        end
    end

    // LED next-state per display mode.
    always_comb begin
        led_next_s = 1'b0;
        case (mode_s)
            LED_DIRECT:    led_next_s = src_s;
            LED_STRETCH:   led_next_s = stretch_out_s;
            LED_TOGGLE:    led_next_s = toggle_next_s;
            LED_HEARTBEAT: led_next_s = src_s & hb_phase_r;
            default:       led_next_s = 1'b0;
        endcase
    end

    // Per-pin debug source selection.
    always_comb begin
        dbg_next_s = {NUM_DBG{1'b0}};
        for (int k = 0; k < NUM_DBG; k++) begin
            dbg_next_s[k] = sel_bit(sync2_r, dbg_sel[k*SEL_W +: SEL_W]);
        end
    end

    probe_pulse_stretcher #(
        .HOLD_CYC    (STRETCH_CYC)
    ) u_stretch (
        .clk_20mhz   (clk_20mhz),
        .rst_n_20mhz (rst_n_20mhz),
        .trig        (edge_s),
        .flush       (cfg_chg_s),
        .out         (stretch_out_s)
    );

    // Edge history, config history, toggle state and saturating edge counter.
    always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
        if (!rst_n_20mhz) begin
            src_d_r     <= 1'b0;
            primed_r    <= 1'b0;
            sel_hist_r  <= {SEL_W{1'b0}};
            mode_hist_r <= LED_DIRECT;
            toggle_r    <= 1'b0;
            edge_cnt    <= {CNT_W{1'b0}};
        end else begin
            src_d_r     <= src_s;
            primed_r    <= 1'b1;
            sel_hist_r  <= led_sel;
            mode_hist_r <= mode_s;
            toggle_r    <= toggle_next_s;
            if (cnt_clr || cfg_chg_s) begin
                edge_cnt <= {CNT_W{1'b0}};
            end else if (edge_s && (edge_cnt != {CNT_W{1'b1}})) begin
                edge_cnt <= edge_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                edge_cnt <= edge_cnt;
            end
        end
    end

    // Free-running heartbeat; deliberately independent of select/mode changes.
    always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
        if (!rst_n_20mhz) begin
            hb_cnt_r   <= {HB_W{1'b0}};
            hb_phase_r <= 1'b0;
        end else if (hb_cnt_r == HB_W'(HB_HALF - 1)) begin
            hb_cnt_r   <= {HB_W{1'b0}};
            hb_phase_r <= ~hb_phase_r;
        end else begin
            hb_cnt_r   <= hb_cnt_r + {{(HB_W-1){1'b0}}, 1'b1};
            hb_phase_r <= hb_phase_r;
        end
    end

    // Registered output pins.
    always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
        if (!rst_n_20mhz) begin
            STATE_LED1 <= 1'b0;
            DEBUG_SIG  <= {NUM_DBG{1'b0}};
        end else begin
            STATE_LED1 <= led_next_s;
            DEBUG_SIG  <= dbg_next_s;
        end
    end

endmodule

// File: tb/tb_debug_probe_mux.sv
// Directed scoreboard bench for debug_probe_mux: stimulus queues expected
// outputs tagged with a cycle number, a monitor compares them on the falling edge.
module tb_debug_probe_mux;

    localparam int NS = 64;
    localparam int ND = 4;
    localparam int SC = 100;
    localparam int HB = 50;
    localparam int CW = 4;

    localparam int SIG_LED = 0;
    localparam int SIG_DBG = 1;
    localparam int SIG_CNT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS-1:0] probe = '0;
    logic [7:0]    led_sel = 8'd5;
    logic [1:0]    led_mode = 2'd0;
    logic [8*ND-1:0] dbg_sel = {8'd63, 8'd7, 8'd5, 8'd200};
    logic          cnt_clr = 1'b0;
    logic          led;
    logic [ND-1:0] dbg;
    logic [CW-1:0] ecnt;

    debug_probe_mux #(
        .NUM_SRC     (NS),
        .NUM_DBG     (ND),
        .STRETCH_CYC (SC),
        .HB_HALF     (HB),
        .CNT_W       (CW)
    ) dut (
        .clk_20mhz   (clk),
        .rst_n_20mhz (rst_n),
        .probe_in    (probe),
        .led_sel     (led_sel),
        .led_mode    (led_mode),
        .dbg_sel     (dbg_sel),
        .cnt_clr     (cnt_clr),
        .STATE_LED1  (led),
        .DEBUG_SIG   (dbg),
        .edge_cnt    (ecnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    at;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Queue an expectation due `ofs` cycles from now, kept sorted by due cycle.
    task automatic sb_push(input string name, input int sig, input int ofs, input int val);
        exp_t e;
        int   i;
        e.at = cyc + ofs;
        e.sig = sig;
        e.val = val;
        e.name = name;
        i = 0;
        while (i < sb.size() && sb[i].at <= e.at) i++;
        sb.insert(i, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        int   act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                if (e.sig == SIG_LED) act = int'(led);
                else if (e.sig == SIG_DBG) act = int'(dbg);
                else act = int'(ecnt);
                n_cmp++;
                if (e.at != cyc || act != e.val) begin
                    n_bad++;
                    $display("FAIL %s: cycle %0d got %0d, expected %0d (due cycle %0d)",
                             e.name, cyc, act, e.val, e.at);
                end
            end
        end
    end

    initial begin : stim
        int waited;
        tick(3);
        sb_push("reset_led", SIG_LED, 0, 0);
        sb_push("reset_dbg", SIG_DBG, 0, 0);
        sb_push("reset_cnt", SIG_CNT, 0, 0);
        tick(1);
        rst_n = 1'b1;
        tick(5);

        // Mode 0: 10-clock pulse on source 5, LED follows 3 clocks later.
        sb_push("m0_led_pre",   SIG_LED, 2, 0);
        sb_push("m0_led_rise",  SIG_LED, 3, 1);
        sb_push("m0_dbg_rise",  SIG_DBG, 3, 2);
        sb_push("m0_led_last",  SIG_LED, 12, 1);
        sb_push("m0_led_fall",  SIG_LED, 13, 0);
        sb_push("m0_dbg_fall",  SIG_DBG, 13, 0);
        probe[5] = 1'b1;
        tick(10);
        probe[5] = 1'b0;
        tick(6);

        // Debug pins: slice 0 selects 200 (out of range) and must read 0.
        sb_push("dbg_ones_old", SIG_DBG, 2, 0);
        sb_push("dbg_ones",     SIG_DBG, 3, 14);
        probe = '1;
        tick(5);
        sb_push("dbg_b63_old",  SIG_DBG, 2, 14);
        sb_push("dbg_b63",      SIG_DBG, 3, 8);
        probe = '0;
        probe[63] = 1'b1;
        tick(5);
        probe = '0;
        tick(5);

        // Mode 1: pulse, then retrigger 60 clocks later -> 160 clocks high.
        led_mode = 2'd1;
        tick(5);
        sb_push("m1_led_pre",   SIG_LED, 3, 0);
        sb_push("m1_led_on",    SIG_LED, 4, 1);
        sb_push("m1_led_mid",   SIG_LED, 100, 1);
        sb_push("m1_led_last",  SIG_LED, 163, 1);
        sb_push("m1_led_off",   SIG_LED, 164, 0);
        probe[5] = 1'b1;
        tick(1);
        probe[5] = 1'b0;
        tick(59);
        probe[5] = 1'b1;
        tick(1);
        probe[5] = 1'b0;
        tick(110);

        // Mode 2: three pulses -> LED 1,0,1 and count 3.
        led_mode = 2'd2;
        tick(5);
        sb_push("m2_cnt_clr",   SIG_CNT, 2, 0);
        sb_push("m2_led_1",     SIG_LED, 3, 1);
        sb_push("m2_cnt_1",     SIG_CNT, 3, 1);
        sb_push("m2_led_2",     SIG_LED, 8, 0);
        sb_push("m2_led_3",     SIG_LED, 13, 1);
        sb_push("m2_cnt_3",     SIG_CNT, 13, 3);
        for (int i = 0; i < 3; i++) begin
            probe[5] = 1'b1;
            tick(1);
            probe[5] = 1'b0;
            tick(4);
        end
        tick(5);

        // 4-bit counter saturates at 15 after 20 pulses.
        sb_push("sat_clr",      SIG_CNT, 1, 0);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        tick(2);
        sb_push("sat_14",       SIG_CNT, 42, 14);
        sb_push("sat_15",       SIG_CNT, 45, 15);
        sb_push("sat_hold",     SIG_CNT, 62, 15);
        for (int i = 0; i < 20; i++) begin
            probe[5] = 1'b1;
            tick(1);
            probe[5] = 1'b0;
            tick(2);
        end
        tick(5);

        // Clear coincident with a counted edge wins.
        sb_push("clr_before",   SIG_CNT, 2, 15);
        sb_push("clr_wins",     SIG_CNT, 3, 0);
        sb_push("clr_stays",    SIG_CNT, 6, 0);
        probe[5] = 1'b1;
        tick(1);
        probe[5] = 1'b0;
        tick(1);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        tick(5);

        // Mode 1 select switch 5->7 with bit 7 high: flush, no new edge.
        led_mode = 2'd1;
        tick(5);
        sb_push("sw_cnt_pre",   SIG_CNT, 3, 1);
        sb_push("sw_led_pre",   SIG_LED, 4, 1);
        sb_push("sw_cnt_clr",   SIG_CNT, 11, 0);
        sb_push("sw_led_off",   SIG_LED, 12, 0);
        sb_push("sw_led_late",  SIG_LED, 30, 0);
        sb_push("sw_cnt_late",  SIG_CNT, 30, 0);
        sb_push("sw_dbg_b7",    SIG_DBG, 30, 4);
        sb_push("sw_led_end",   SIG_LED, 110, 0);
        probe[5] = 1'b1;
        probe[7] = 1'b1;
        tick(1);
        probe[5] = 1'b0;
        tick(9);
        led_sel = 8'd7;
        tick(105);

        // Reset mid-stretch, then heartbeat-gated LED stays low HB_HALF clocks.
        led_sel = 8'd5;
        tick(5);
        sb_push("rs_cnt_pre",   SIG_CNT, 3, 1);
        sb_push("rs_led_pre",   SIG_LED, 4, 1);
        sb_push("rs_dbg_pre",   SIG_DBG, 19, 4);
        probe[5] = 1'b1;
        tick(1);
        probe[5] = 1'b0;
        tick(19);
        rst_n = 1'b0;
        led_mode = 2'd3;
        probe[5] = 1'b1;
        sb_push("rs_led_now",   SIG_LED, 0, 0);
        sb_push("rs_dbg_now",   SIG_DBG, 0, 0);
        sb_push("rs_cnt_now",   SIG_CNT, 0, 0);
        tick(3);
        rst_n = 1'b1;
        sb_push("hb_led_1",     SIG_LED, 1, 0);
        sb_push("hb_led_30",    SIG_LED, 30, 0);
        sb_push("hb_led_50",    SIG_LED, 50, 0);
        sb_push("hb_led_on",    SIG_LED, 51, 1);
        sb_push("hb_led_100",   SIG_LED, 100, 1);
        sb_push("hb_led_off",   SIG_LED, 101, 0);
        tick(105);

        waited = 0;
        while (sb.size() > 0 && waited < 200) begin
            tick(1);
            waited++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations still pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debug_probe_mux.md
DEBUG_PROBE_MUX -- requirements
Module: debug_probe_mux

Interface
REQ-001 SHALL have parameter NUM_SRC, default 64, number of probe sources (1..256).
REQ-002 SHALL have parameter NUM_DBG, default 4, number of DEBUG_SIG outputs (1..16).
REQ-003 SHALL have parameter STRETCH_CYC, default 2000000, pulse-stretch hold in clocks (100 ms at 20 MHz).
REQ-004 SHALL have parameter HB_HALF, default 10000000, heartbeat half-period in clocks.
REQ-005 SHALL have parameter CNT_W, default 16, edge-counter width.
REQ-006 SHALL have port clk_20mhz  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n_20mhz  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port probe_in  in  NUM_SRC  asynchronous probe sources.
REQ-009 SHALL have port led_sel  in  8  LED source index.
REQ-010 SHALL have port led_mode  in  2  LED mode: 0 direct, 1 stretch, 2 toggle, 3 heartbeat-gated.
REQ-011 SHALL have port dbg_sel  in  8*NUM_DBG  per-output source index; slice k = bits [8k+7:8k].
REQ-012 SHALL have port cnt_clr  in  1  synchronous edge-counter clear.
REQ-013 SHALL have port STATE_LED1  out  1  LED drive.
REQ-014 SHALL have port DEBUG_SIG  out  NUM_DBG  debug pins.
REQ-015 SHALL have port edge_cnt  out  CNT_W  rising-edge count of the LED source.

Function
REQ-016 SHALL pass every probe_in bit through a 2-flop synchronizer; all further logic uses synchronized bits.
REQ-017 SHALL drive a selected bit as 0 when the index is >= NUM_SRC.
REQ-018 SHALL register DEBUG_SIG[k] = sync[dbg_sel slice k]; probe_in to pin latency is 3 clocks.
REQ-019 SHALL detect LED-source rising edges as sync bit high while its 1-clock delayed copy is low.
REQ-020 SHALL, in mode 0, output the selected bit registered, with 3-clock latency.
REQ-021 SHALL, in mode 1, set STATE_LED1 on a rising edge and hold it STRETCH_CYC clocks.
REQ-022 SHALL make mode 1 retriggerable: an edge during a hold reloads the counter to STRETCH_CYC.
REQ-023 SHALL, in mode 2, invert STATE_LED1 on each rising edge.
REQ-024 SHALL, in mode 3, drive STATE_LED1 = selected bit AND heartbeat.
REQ-025 SHALL free-run the heartbeat from reset, toggling every HB_HALF clocks.
REQ-026 SHALL increment edge_cnt by 1 per rising edge and saturate at all-ones (no wrap).
REQ-027 SHALL give cnt_clr priority over a same-cycle increment; edge_cnt reads 0 the next clock.
REQ-028 SHALL, when led_sel or led_mode differs from its 1-clock delayed copy:
 - clear the stretch counter, toggle state and edge_cnt, and re-prime the edge detector;
 - not count an edge in that cycle;
 - not produce a spurious edge from the source switch.
REQ-029 SHALL leave the heartbeat counter undisturbed by select or mode changes.

Reset
REQ-030 SHALL on reset assertion immediately clear all of:
 - synchronizer flops;
 - edge-detect flops and select/mode history;
 - stretch counter, toggle state and heartbeat counter/phase;
 - edge_cnt, STATE_LED1 and DEBUG_SIG.
REQ-031 SHALL abort an in-progress stretch or heartbeat on mid-operation reset, restarting from zero after release.
REQ-032 SHALL not count an edge on the first clock after reset release even if the source is already high.

Structure
REQ-033 SHALL place these in shared package debug_probe_pkg:
 - led_mode_e enum (LED_DIRECT, LED_STRETCH, LED_TOGGLE, LED_HEARTBEAT);
 - SEL_W = 8;
 - default STRETCH_CYC and HB_HALF constants.
REQ-034 SHALL implement the retriggerable hold as one sub-module, probe_pulse_stretcher:
 - parameter HOLD_CYC;
 - ports clk_20mhz, rst_n_20mhz, trig, flush, out.
REQ-035 SHALL size counters with $clog2 of their parameter.

Verification
REQ-036 SHALL cover mode 0 with led_sel=5, probe_in[5] pulse 10 clocks -> STATE_LED1 high 10 clocks, starting 3 clocks later.
REQ-037 SHALL cover mode 1 with STRETCH_CYC=100 and a 1-clock pulse, then a second pulse 60 clocks later -> LED high 160 clocks.
REQ-038 SHALL cover mode 2 with 3 pulses on the selected source -> LED 1,0,1 and edge_cnt=3.
REQ-039 SHALL cover CNT_W=4 with 20 pulses -> edge_cnt=15; cnt_clr coincident with a pulse -> edge_cnt=0.
REQ-040 SHALL cover led_sel change 5->7 with bit 7 held high and mode 1 -> no stretch, edge_cnt=0; dbg_sel slice=200 with NUM_SRC=64 -> DEBUG_SIG bit 0.
REQ-041 SHALL cover reset asserted mid-stretch and mid-heartbeat -> all outputs 0 at once; after release, mode 3 LED stays low for HB_HALF clocks.
